usb_frame_receiver: RTL
=======================

# usb_frame_receiver

FT245-style FIFO receiver for the USB host-to-FPGA direction. It is the counterpart of the byte-wise word transmitter used to return pulse heights. It reads 5-byte command frames from the FT245 receive FIFO: one command byte followed by a 32-bit little-endian argument. Each assembled frame is presented to the control logic through a valid/ready handshake, so the host can set thresholds and start/stop acquisition with parameters.

## Interface
Parameters:
- RD_PULSE, 2: cycles `rd` is held low per byte read (≥1).
- RD_RECOVER, 2: cycles `rd` is held high after each read before `rxf` is examined again (≥1).
- TIMEOUT_CYCLES, 32'd1000000: maximum idle gap between bytes of one frame.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- reset, input, 1: asynchronous, active-low reset.
- enable, input, 1: high means the block may start new byte reads; low means the block yields the FT245 bus.
- rxf, input, 1: FT245 RX-FIFO-not-empty, active low, asynchronous to `clk`.
- data_in, input, 8: FT245 data bus.
- rd, output, 1: FT245 read strobe, active low.
- wr, output, 1: FT245 write strobe; constant 1, driven from a register.
- frame_cmd, output, 8: command byte (frame byte 0).
- frame_word, output, 32: argument; byte 1 goes to [7:0], byte 4 to [31:24].
- frame_valid, output, 1: frame_cmd/frame_word are valid; held until accepted.
- frame_ready, input, 1: consumer accepts a frame when both valid and ready are high at a rising edge.
- frame_error, output, 1: one-cycle pulse when a partial frame is discarded.
- busy, output, 1: high when byte_idx≠0, and in RD_LOW, RECOVER and HOLD.

## Operation
- `rxf` passes through a 2-flop synchronizer; FSM decisions use only `rxf_s`.
- IDLE:
  - If `enable` is high and `rxf_s` is low, set rd←0 and go to RD_LOW.
  - Otherwise stay in IDLE.
- RD_LOW:
  - Count RD_PULSE cycles with `rd` low.
  - On the last cycle's edge, capture `data_in` into the byte slot at byte_idx and set rd←1.
  - If byte_idx==4, go to HOLD; otherwise byte_idx←byte_idx+1 and go to RECOVER.
- RECOVER:
  - Hold `rd` high for RD_RECOVER cycles, ignoring `rxf_s`, then go to IDLE.
- HOLD:
  - frame_valid is 1 and `rd` stays high, even if `rxf` is low.
  - On handshake: frame_valid←0, byte_idx←0, go to RECOVER.
- Register update:
  - frame_cmd and frame_word update only when the frame completes (on the edge that captures byte 4).
  - They are stable throughout HOLD and hold their values after acceptance.
- Bytes are assembled in a shadow register, so outputs never show a partial frame.
- `enable` going low during RD_LOW or RECOVER does not abort the byte; it only blocks the next IDLE→RD_LOW transition. A partial frame is kept across an `enable` low period.
- `wr` is always 1; the block never writes to the FT245.

## Timing
- Reset values (asynchronous, while reset is low):
  - rd=1, wr=1, frame_cmd=0, frame_word=0, frame_valid=0, frame_error=0, busy=0.
  - byte_idx=0, synchronizer flops=1, state=IDLE.
  - Reset during RD_LOW returns `rd` high immediately and discards the partial frame.
- `rxf` falling (setup met) with block idle and `enable` high: `rd` falls on the 3rd rising edge.
- `rd` low time is exactly RD_PULSE cycles. `data_in` is sampled at the edge that raises `rd`.
- Byte period with `rxf` continuously low: RD_PULSE + RD_RECOVER + 1 cycles.
- Frame latency:
  - frame_valid rises on the edge that captures byte 4.
  - Earliest acceptance is that cycle plus one edge.
  - After acceptance, the next `rd` is no earlier than RD_RECOVER+1 cycles later.
- frame_error: single-cycle high; never coincides with frame_valid.

## Configuration
- USB_RX_TIMEOUT_EN defined:
  - A 32-bit gap counter runs in IDLE while byte_idx≠0 and clears on each RD_LOW entry.
  - When it reaches TIMEOUT_CYCLES: byte_idx←0, frame_error pulses, and the next byte is treated as a command byte.
- USB_RX_TIMEOUT_EN undefined:
  - No gap counter; a partial frame waits indefinitely.
  - frame_error is constant 0.
  - TIMEOUT_CYCLES is unused.

## Test plan
- Single frame: bytes A5,78,56,34,12 with frame_ready=1 → one frame_valid with frame_cmd=8'hA5, frame_word=32'h12345678; frame_error=0; exactly 5 `rd` pulses.
- Backpressure: frame_ready=0 for 20 cycles after frame_valid while `rxf` stays low → frame_valid and data held steady and `rd` stays high; then frame_ready=1 → next frame's first `rd` falls RD_RECOVER+1 cycles after acceptance.
- Strobe shape: RD_PULSE=3, RD_RECOVER=4 → `rd` low exactly 3 cycles and high at least 4 between bytes; data_in changed 1 cycle before the `rd` rising edge is captured correctly.
- Timeout (macro defined, TIMEOUT_CYCLES=50): 2 bytes sent, then `rxf` high for 60 cycles → one frame_error pulse; following frame 01,EF,BE,AD,DE decodes to cmd=8'h01, word=32'hDEADBEEF. Macro undefined: same frame yields cmd=8'h01 only when aligned, and no frame_error.
- Enable gating: `rxf` low with enable=0 for 30 cycles → `rd` stays 1 and busy=0; enable=1 → `rd` falls within 1 cycle; enable dropped mid-byte → that byte completes.
- Reset mid-read: reset low while `rd`=0 on byte 3 → `rd`=1 and all outputs 0 immediately; after release, a fresh 5-byte frame decodes correctly.

Source files
------------

// File: rtl/usb_frame_receiver.sv
// usb_frame_receiver
//   Reads 5-byte command frames (command byte + 32-bit little-endian argument)
//   from an FT245 receive FIFO and hands each complete frame to the control
//   logic through a valid/ready handshake.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   enable       allow new byte reads; low yields the FT245 bus
//   rxf          FT245 RX-not-empty, active low, asynchronous to clk
//   data_in      FT245 data bus
//   rd           FT245 read strobe, active low
//   wr           FT245 write strobe, held at 1
//   frame_cmd    frame byte 0
//   frame_word   frame bytes 1..4, byte 1 in [7:0]
//   frame_valid  frame_cmd/frame_word valid, held until accepted
//   frame_ready  consumer accepts on valid & ready
//   frame_error  one-cycle pulse when a partial frame is dropped
//   busy         partial frame held or a read/recover/hold in progress
//
// Build option
//   USB_RX_TIMEOUT_EN  enables the inter-byte gap timeout that drops a
//                      stalled partial frame. Without it a partial frame
//                      waits indefinitely and frame_error stays 0.
module usb_frame_receiver #(
  parameter int unsigned RD_PULSE       = 2,
  parameter int unsigned RD_RECOVER     = 2,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        rxf,
  input  logic [7:0]  data_in,
  output logic        rd,
  output logic        wr,
  output logic [7:0]  frame_cmd,
  output logic [31:0] frame_word,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        frame_error,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RD_LOW, RECOVER, HOLD} state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  byte_idx, idx_n;
  logic        rd_n, valid_n, err_n, cap;
  logic        rxf_m, rxf_s;
  logic        timeout;
  logic [31:0] shadow;  // bytes 0..3 of the frame being assembled

  // rxf synchronizer, idles high (FIFO empty)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxf_m <= 1'b1;
      rxf_s <= 1'b1;
    end else begin
      rxf_m <= rxf;
      rxf_s <= rxf_m;
    end
  end

`ifdef USB_RX_TIMEOUT_EN
  logic [31:0] gap, gap_n;

  // Fires on the idle cycle that would bring the gap count to TIMEOUT_CYCLES.
  assign timeout = (state == IDLE) && (byte_idx != 3'd0) &&
                   (gap + 32'd1 == TIMEOUT_CYCLES);

  always_comb begin
    gap_n = gap;
    if (state == RD_LOW || timeout)            gap_n = '0;
    else if (state == IDLE && byte_idx != 3'd0) gap_n = gap + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) gap <= '0;
    else        gap <= gap_n;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = byte_idx;
    rd_n    = rd;
    valid_n = frame_valid;
    err_n   = 1'b0;
    cap     = 1'b0;
    unique case (state)
      IDLE: begin
        if (timeout) begin
          // drop the stalled partial frame; next byte is a command byte
          idx_n = 3'd0;
          err_n = 1'b1;
        end else if (enable && !rxf_s) begin
          rd_n    = 1'b0;
          cnt_n   = '0;
          state_n = RD_LOW;
        end
      end
      RD_LOW: begin
        if (cnt == 16'(RD_PULSE - 1)) begin
          cap   = 1'b1;
          rd_n  = 1'b1;
          cnt_n = '0;
          if (byte_idx == 3'd4) begin
            valid_n = 1'b1;
            state_n = HOLD;
          end else begin
            idx_n   = byte_idx + 3'd1;
            state_n = RECOVER;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      RECOVER: begin
        if (cnt == 16'(RD_RECOVER - 1)) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      HOLD: begin
        if (frame_ready) begin
          valid_n = 1'b0;
          idx_n   = 3'd0;
          cnt_n   = '0;
          state_n = RECOVER;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      byte_idx    <= 3'd0;
      rd          <= 1'b1;
      wr          <= 1'b1;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      byte_idx    <= idx_n;
      rd          <= rd_n;
      wr          <= 1'b1;
      frame_valid <= valid_n;
      frame_error <= err_n;
    end
  end

  // Outputs only change when the last byte lands, so a partial frame is
  // never visible on frame_cmd/frame_word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow     <= '0;
      frame_cmd  <= '0;
      frame_word <= '0;
    end else if (cap) begin
      if (byte_idx == 3'd4) begin
        frame_cmd  <= shadow[7:0];
        frame_word <= {data_in, shadow[31:8]};
      end else begin
        shadow[{byte_idx[1:0], 3'b000} +: 8] <= data_in;
      end
    end
  end

  assign busy = (byte_idx != 3'd0) || (state != IDLE);

endmodule
